// File: rtl/rsqrt_arbiter_if.sv
// Request, response and core-side signals of the shared rsqrt/sqrt arbiter.
// The slave view belongs to the arbiter; the master view to its environment.
interface rsqrt_arbiter_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = $clog2(N_REQ)
);
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ*32-1:0] req_in;
    logic [N_REQ*32-1:0] req_est;

    logic                rsp_valid;
    logic                rsp_ready;
    logic [ID_W-1:0]     rsp_id;
    logic [1:0]          rsp_status;
    logic [31:0]         rsp_rsqrt;
    logic [31:0]         rsp_sqrt;

    logic                core_start;
    logic [31:0]         core_in;
    logic [31:0]         core_est;
    logic                core_valid;
    logic [31:0]         core_rsqrt;
    logic [31:0]         core_sqrt;

    modport slave (
        input  req_valid, req_in, req_est, rsp_ready, core_valid, core_rsqrt, core_sqrt,
        output req_ready, rsp_valid, rsp_id, rsp_status, rsp_rsqrt, rsp_sqrt,
        output core_start, core_in, core_est
    );

    modport master (
        output req_valid, req_in, req_est, rsp_ready, core_valid, core_rsqrt, core_sqrt,
        input  req_ready, rsp_valid, rsp_id, rsp_status, rsp_rsqrt, rsp_sqrt,
        input  core_start, core_in, core_est
    );
endinterface

// File: rtl/rsqrt_arbiter.sv
// Round-robin arbiter sharing one Goldschmidt rsqrt/sqrt core among N_REQ requesters,
// with non-positive operand screening and a watchdog on the core handshake.
module rsqrt_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned ID_W    = $clog2(N_REQ)
) (
    input  logic           clk,
    input  logic           resetn,
    rsqrt_arbiter_if.slave bus
);
    localparam int unsigned TimerW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [TimerW-1:0] timer_q, timer_d, timer_inc;
    logic              core_start_q, core_start_d;
    logic [31:0]       core_in_q, core_in_d;
    logic [31:0]       core_est_q, core_est_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [1:0]        rsp_status_q, rsp_status_d;
    logic [31:0]       rsp_rsqrt_q, rsp_rsqrt_d;
    logic [31:0]       rsp_sqrt_q, rsp_sqrt_d;

    logic              gnt_found;
    logic [ID_W-1:0]   gnt_idx;
    logic [ID_W-1:0]   cand;
    int unsigned       scan;
    logic [31:0]       sel_in, sel_est;

    assign timer_inc = timer_q + TimerW'(1);
    assign sel_in    = bus.req_in[{gnt_idx, 5'b0} +: 32];
    assign sel_est   = bus.req_est[{gnt_idx, 5'b0} +: 32];

    // First requesting slot after the last grant, wrapping modulo N_REQ.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        scan      = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            scan = (32'(ptr_q) + 32'd1 + k) % N_REQ;
            cand = ID_W'(scan);
            if (!gnt_found && bus.req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (state_q == StIdle && gnt_found) begin
            bus.req_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        timer_d      = timer_q;
        core_start_d = 1'b0;
        core_in_d    = core_in_q;
        core_est_d   = core_est_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_status_d = rsp_status_q;
        rsp_rsqrt_d  = rsp_rsqrt_q;
        rsp_sqrt_d   = rsp_sqrt_q;

        case (state_q)
            StIdle: begin
                if (gnt_found) begin
                    ptr_d    = gnt_idx;
                    rsp_id_d = gnt_idx;
                    if ($signed(sel_in) <= 0) begin
                        rsp_status_d = 2'b01;
                        rsp_rsqrt_d  = 32'h7FFF_FFFF;
                        rsp_sqrt_d   = '0;
                        rsp_valid_d  = 1'b1;
                        state_d      = StResp;
                    end else begin
                        core_in_d    = sel_in;
                        core_est_d   = sel_est;
                        core_start_d = 1'b1;
                        state_d      = StIssue;
                    end
                end
            end
            StIssue: begin
                timer_d = '0;
                state_d = StWait;
            end
            StWait: begin
                // A completion arriving on the watchdog's last cycle still counts.
                if (bus.core_valid) begin
                    rsp_status_d = 2'b00;
                    rsp_rsqrt_d  = bus.core_rsqrt;
                    rsp_sqrt_d   = bus.core_sqrt;
                    rsp_valid_d  = 1'b1;
                    core_in_d    = '0;
                    core_est_d   = '0;
                    state_d      = StResp;
                end else if (timer_inc == TimerW'(TIMEOUT - 1)) begin
                    rsp_status_d = 2'b10;
                    rsp_rsqrt_d  = '0;
                    rsp_sqrt_d   = '0;
                    rsp_valid_d  = 1'b1;
                    core_in_d    = '0;
                    core_est_d   = '0;
                    state_d      = StResp;
                end else begin
                    timer_d = timer_inc;
                end
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StIdle;
            ptr_q        <= ID_W'(N_REQ - 1);
            timer_q      <= '0;
            core_start_q <= 1'b0;
            core_in_q    <= '0;
            core_est_q   <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_status_q <= '0;
            rsp_rsqrt_q  <= '0;
            rsp_sqrt_q   <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            timer_q      <= timer_d;
            core_start_q <= core_start_d;
            core_in_q    <= core_in_d;
            core_est_q   <= core_est_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_status_q <= rsp_status_d;
            rsp_rsqrt_q  <= rsp_rsqrt_d;
            rsp_sqrt_q   <= rsp_sqrt_d;
        end
    end

    assign bus.core_start = core_start_q;
    assign bus.core_in    = core_in_q;
    assign bus.core_est   = core_est_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_status = rsp_status_q;
    assign bus.rsp_rsqrt  = rsp_rsqrt_q;
    assign bus.rsp_sqrt   = rsp_sqrt_q;
endmodule

// File: tb/tb_rsqrt_arbiter.sv
// Directed bench for rsqrt_arbiter: a latency-programmable core model plus a response
// scoreboard filled at each accept and drained at each response handshake.
module tb_rsqrt_arbiter;
    localparam int unsigned NR = 4;

    typedef struct packed {
        logic [1:0]  id;
        logic [1:0]  st;
        logic [31:0] rs;
        logic [31:0] sq;
    } rsp_t;

    logic clk;
    logic resetn;

    rsqrt_arbiter_if #(.N_REQ(NR), .ID_W(2)) bus ();

    rsqrt_arbiter #(.N_REQ(NR), .TIMEOUT(64), .ID_W(2)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          core_lat = 6;
    int          kick_req = 0;
    int          n_starts = 0;
    int          n_ready  = 0;
    int          n_rsp    = 0;
    int          acc_cyc  = 0;
    int          rsp_cyc  = 0;
    int          last_g   = 0;
    bit          got_acc  = 1'b0;
    bit          got_rsp  = 1'b0;
    bit          auto_drop = 1'b1;
    logic [3:0]  acc_mask = '0;
    rsp_t        sb[$];
    int          grant_log[$];

    int          cm_cnt    = 0;
    int          kick_seen = 0;
    logic [31:0] cm_in     = '0;
    logic [31:0] cm_est    = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // x * (1/sqrt(x)) = sqrt(x), truncated back to Q16.16.
    function automatic logic [31:0] core_sqrt_f(input logic [31:0] x, input logic [31:0] e);
        logic [63:0] p;
        p = {32'b0, x} * {32'b0, e};
        return p[47:16];
    endfunction

    function automatic rsp_t expect_f(input int g, input logic [31:0] x, input logic [31:0] e);
        rsp_t r;
        r.id = 2'(g);
        if ($signed(x) <= 0) begin
            r.st = 2'b01; r.rs = 32'h7FFF_FFFF; r.sq = '0;
        end else if (core_lat == 0) begin
            r.st = 2'b10; r.rs = '0; r.sq = '0;
        end else begin
            r.st = 2'b00; r.rs = e; r.sq = core_sqrt_f(x, e);
        end
        return r;
    endfunction

    // Core model: answers core_lat cycles after core_start (never if 0), plus forced stray pulses.
    initial begin
        bus.core_valid = 1'b0;
        bus.core_rsqrt = '0;
        bus.core_sqrt  = '0;
        forever begin
            @(negedge clk);
            bus.core_valid = 1'b0;
            if (kick_seen != kick_req) begin
                kick_seen      = kick_req;
                bus.core_valid = 1'b1;
                bus.core_rsqrt = 32'h0000_1234;
                bus.core_sqrt  = 32'h0000_5678;
            end
            if (cm_cnt > 0) begin
                cm_cnt--;
                if (cm_cnt == 0) begin
                    bus.core_valid = 1'b1;
                    bus.core_rsqrt = cm_est;
                    bus.core_sqrt  = core_sqrt_f(cm_in, cm_est);
                end
            end
            if (bus.core_start && core_lat > 0) begin
                cm_cnt = core_lat;
                cm_in  = bus.core_in;
                cm_est = bus.core_est;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic observe();
        logic [3:0] rr;
        int         g;
        rsp_t       e;
        cyc++;
        rr       = bus.req_ready;
        acc_mask = '0;
        chk("ready_onehot", 64'($onehot0(rr)), 64'd1);
        if (rr != 4'b0) begin
            g = 0;
            for (int i = 0; i < int'(NR); i++) if (rr[i]) g = i;
            acc_mask = rr;
            got_acc  = 1'b1;
            acc_cyc  = cyc;
            last_g   = g;
            n_ready++;
            grant_log.push_back(g);
            sb.push_back(expect_f(g, bus.req_in[32*g +: 32], bus.req_est[32*g +: 32]));
        end
        if (bus.core_start) n_starts++;
        if (bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 64'(bus.rsp_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_id", 64'(bus.rsp_id), 64'(e.id));
                chk("sb_status", 64'(bus.rsp_status), 64'(e.st));
                chk("sb_rsqrt", 64'(bus.rsp_rsqrt), 64'(e.rs));
                chk("sb_sqrt", 64'(bus.rsp_sqrt), 64'(e.sq));
            end
            got_rsp = 1'b1;
            rsp_cyc = cyc;
            n_rsp++;
        end
    endtask

    // Observe mid-cycle, then step past the next rising edge.
    task automatic tick();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
        if (auto_drop) bus.req_valid = bus.req_valid & ~acc_mask;
    endtask

    task automatic wait_accept(input int budget);
        int n = 0;
        got_acc = 1'b0;
        while (!got_acc && n < budget) begin tick(); n++; end
        chk("accept_seen", 64'(got_acc), 64'd1);
    endtask

    task automatic wait_rsp(input int budget);
        int n = 0;
        got_rsp = 1'b0;
        while (!got_rsp && n < budget) begin tick(); n++; end
        chk("rsp_seen", 64'(got_rsp), 64'd1);
    endtask

    task automatic set_req(input int i, input logic [31:0] x, input logic [31:0] e);
        bus.req_in[32*i +: 32]  = x;
        bus.req_est[32*i +: 32] = e;
        bus.req_valid[i]        = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'd0);
        chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
        chk({tag, "_rsp_id"}, 64'(bus.rsp_id), 64'd0);
        chk({tag, "_rsp_status"}, 64'(bus.rsp_status), 64'd0);
        chk({tag, "_rsp_rsqrt"}, 64'(bus.rsp_rsqrt), 64'd0);
        chk({tag, "_rsp_sqrt"}, 64'(bus.rsp_sqrt), 64'd0);
        chk({tag, "_core_start"}, 64'(bus.core_start), 64'd0);
        chk({tag, "_core_in"}, 64'(bus.core_in), 64'd0);
        chk({tag, "_core_est"}, 64'(bus.core_est), 64'd0);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        sb.delete();
        tick();
        tick();
        resetn = 1'b1;
    endtask

    initial begin
        int         n;
        int         base;
        int         s0;
        logic [67:0] hold;

        resetn        = 1'b0;
        bus.req_valid = '0;
        bus.req_in    = '0;
        bus.req_est   = '0;
        bus.rsp_ready = 1'b1;
        tick();
        tick();
        chk_all_zero("reset");
        resetn = 1'b1;
        tick();

        // Single request, core latency 6.
        n_ready  = 0;
        s0       = n_starts;
        core_lat = 6;
        set_req(0, 32'h0004_0000, 32'h0000_8000);
        wait_accept(20);
        chk("t1_start", 64'(bus.core_start), 64'd1);
        for (int i = 1; i <= 7; i++) begin
            chk("t1_core_in", 64'(bus.core_in), 64'h0004_0000);
            chk("t1_core_est", 64'(bus.core_est), 64'h0000_8000);
            chk("t1_rsp_early", 64'(bus.rsp_valid), 64'd0);
            tick();
        end
        chk("t1_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        chk("t1_rsp_id", 64'(bus.rsp_id), 64'd0);
        chk("t1_rsp_status", 64'(bus.rsp_status), 64'd0);
        chk("t1_rsqrt", 64'(bus.rsp_rsqrt), 64'h0000_8000);
        chk("t1_sqrt", 64'(bus.rsp_sqrt), 64'h0002_0000);
        wait_rsp(5);
        chk("t1_one_start", 64'(n_starts - s0), 64'd1);
        chk("t1_one_ready", 64'(n_ready), 64'd1);

        // Contention from a fresh reset: all four held high.
        do_reset();
        core_lat  = 3;
        auto_drop = 1'b0;
        grant_log.delete();
        for (int i = 0; i < int'(NR); i++) begin
            set_req(i, 32'h0001_0000 * (i + 1), 32'h0000_8000 + 32'h0000_1000 * i);
        end
        base = n_rsp;
        n    = 0;
        while (n_rsp < base + 5 && n < 300) begin tick(); n++; end
        bus.req_valid = '0;
        auto_drop     = 1'b1;
        chk("t2_grants", 64'(grant_log.size()), 64'd5);
        if (grant_log.size() == 5) begin
            chk("t2_order0", 64'(grant_log[0]), 64'd0);
            chk("t2_order1", 64'(grant_log[1]), 64'd1);
            chk("t2_order2", 64'(grant_log[2]), 64'd2);
            chk("t2_order3", 64'(grant_log[3]), 64'd3);
            chk("t2_order4", 64'(grant_log[4]), 64'd0);
        end

        // Domain errors: zero and -1.0.
        s0 = n_starts;
        set_req(0, 32'h0000_0000, 32'h0001_0000);
        wait_accept(20);
        chk("t3a_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        chk("t3a_status", 64'(bus.rsp_status), 64'd1);
        chk("t3a_rsqrt", 64'(bus.rsp_rsqrt), 64'h7FFF_FFFF);
        chk("t3a_sqrt", 64'(bus.rsp_sqrt), 64'd0);
        wait_rsp(5);
        set_req(0, 32'hFFFF_0000, 32'h0001_0000);
        wait_accept(20);
        chk("t3b_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        chk("t3b_status", 64'(bus.rsp_status), 64'd1);
        chk("t3b_rsqrt", 64'(bus.rsp_rsqrt), 64'h7FFF_FFFF);
        wait_rsp(5);
        chk("t3_no_start", 64'(n_starts - s0), 64'd0);

        // Watchdog: the core never answers.
        core_lat = 0;
        set_req(0, 32'h0009_0000, 32'h0000_5555);
        wait_accept(20);
        chk("t4_start", 64'(bus.core_start), 64'd1);
        n = 0;
        while (!bus.rsp_valid && n < 100) begin tick(); n++; end
        chk("t4_timeout_lat", 64'(n), 64'd64);
        chk("t4_status", 64'(bus.rsp_status), 64'd2);
        chk("t4_rsqrt", 64'(bus.rsp_rsqrt), 64'd0);
        chk("t4_sqrt", 64'(bus.rsp_sqrt), 64'd0);
        wait_rsp(5);
        base = n_rsp;
        kick_req++;
        repeat (10) tick();
        chk("t4_late_ignored", 64'(n_rsp - base), 64'd0);
        chk("t4_late_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        core_lat = 4;

        // Backpressure with requester 1 pending.
        bus.rsp_ready = 1'b0;
        core_lat      = 2;
        set_req(0, 32'h0002_0000, 32'h0000_B505);
        wait_accept(20);
        set_req(1, 32'h0010_0000, 32'h0000_4000);
        n = 0;
        while (!bus.rsp_valid && n < 20) begin tick(); n++; end
        chk("t5_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        hold = {bus.rsp_id, bus.rsp_status, bus.rsp_rsqrt, bus.rsp_sqrt};
        for (int i = 0; i < 5; i++) begin
            chk("t5_ready_low", 64'(bus.req_ready), 64'd0);
            chk("t5_stable", 64'({bus.rsp_id, bus.rsp_status, bus.rsp_rsqrt, bus.rsp_sqrt}),
                64'(hold));
            chk("t5_valid_held", 64'(bus.rsp_valid), 64'd1);
            tick();
        end
        bus.rsp_ready = 1'b1;
        got_rsp = 1'b0;
        tick();
        chk("t5_handshake", 64'(got_rsp), 64'd1);
        got_acc = 1'b0;
        tick();
        chk("t5_accept_next", 64'(got_acc), 64'd1);
        chk("t5_accept_cyc", 64'(acc_cyc), 64'(rsp_cyc + 1));
        chk("t5_grant1", 64'(last_g), 64'd1);
        wait_rsp(20);

        // Reset during WAIT; the late core pulse must not produce a response.
        core_lat = 10;
        set_req(2, 32'h0003_0000, 32'h0000_93CD);
        wait_accept(20);
        chk("t6_grant2", 64'(last_g), 64'd2);
        repeat (3) tick();
        resetn = 1'b0;
        #1;
        chk_all_zero("t6_reset");
        sb.delete();
        tick();
        tick();
        resetn = 1'b1;
        base   = n_rsp;
        repeat (15) tick();
        chk("t6_no_rsp", 64'(n_rsp - base), 64'd0);
        chk("t6_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        core_lat = 3;
        for (int i = 0; i < int'(NR); i++) set_req(i, 32'h0000_4000, 32'h0002_0000);
        wait_accept(20);
        bus.req_valid = '0;
        chk("t6_grant0", 64'(last_g), 64'd0);
        wait_rsp(20);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/rsqrt_arbiter.md
Name: rsqrt_arbiter

Overview:
Shares one Goldschmidt rsqrt/sqrt core among N_REQ requesters, such as the per-lane vector-normalize units in the ray pipeline.
It picks requesters round-robin and sequences the core's start/valid handshake. It returns the rsqrt and sqrt results on a single response bus tagged with the requester id.
It also screens out non-positive operands and guards against a hung core with a watchdog.
All values are signed fixed point Q16.16 on 32 bits.

Parameters:
N_REQ, 4, number of requesters (2..16)
TIMEOUT, 64, max cycles in WAIT before the watchdog fires (>=2)
ID_W, $clog2(N_REQ), width of the requester id

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
req_valid  in  N_REQ  per-requester request valid
req_ready  out  N_REQ  per-requester accept strobe (one-hot or zero)
req_in  in  N_REQ*32  operand x per requester, Q16.16, slot i at [32i+31:32i]
req_est  in  N_REQ*32  initial 1/sqrt(x) estimate per requester, Q16.16
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_id  out  ID_W  id of the requester that owns the response
rsp_status  out  2  00 ok, 01 domain error (x<=0), 10 timeout
rsp_rsqrt  out  32  1/sqrt(x), Q16.16
rsp_sqrt  out  32  sqrt(x), Q16.16
core_start  out  1  single-cycle start pulse to the core
core_in  out  32  operand to the core
core_est  out  32  estimate to the core
core_valid  in  1  core done pulse
core_rsqrt  in  32  core rsqrt result
core_sqrt  in  32  core sqrt result

Behaviour:
- Reset: state=IDLE, ptr=N_REQ-1 so requester 0 has first priority. All outputs are 0: req_ready, rsp_*, core_start, core_in, core_est. Timer=0. An asserted reset aborts any operation immediately; the response is lost and nothing is replayed.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, arbitration:
  - If any req_valid, grant the first set bit searching from ptr+1 upward, wrapping modulo N_REQ.
  - In the same cycle: req_ready[g]=1 (combinational, one-hot), latch req_in[g], req_est[g] and id=g, and set ptr=g.
  - If the latched x is <=0 (signed): go to RESP with status=01, rsqrt=0x7FFFFFFF, sqrt=0. No core_start is issued.
  - Otherwise go to ISSUE.
- ISSUE: core_start=1 for exactly one cycle, timer cleared, go to WAIT.
- core_in and core_est hold the latched operands from ISSUE through the end of WAIT. They are stable while the core runs.
- WAIT:
  - On core_valid: capture core_rsqrt and core_sqrt, status=00, go to RESP.
  - Otherwise timer++. When timer==TIMEOUT-1 and core_valid is still 0: status=10, results=0, go to RESP.
  - If core_valid and the timeout arrive in the same cycle, core_valid wins.
- core_valid seen in any state other than WAIT is ignored (stale pulse).
- RESP: rsp_valid=1 with rsp_id, rsp_status and results held stable until rsp_ready. On the cycle where rsp_valid&&rsp_ready, go to IDLE. No new request is accepted while in RESP, so at most one operation is outstanding.
- Latency:
  - Accept at cycle T, core_start at T+1.
  - If the core returns valid at T+1+L, rsp_valid rises at T+2+L.
  - Domain error: rsp_valid at T+1.
- Registered outputs: rsp_*, core_start, core_in, core_est. Combinational output: req_ready only.
- Fairness: a requester that holds req_valid is granted within N_REQ operations.

Test Plan:
- Single request: resetn release; req_valid[0]=1, req_in=0x00040000 (4.0), req_est=0x00008000; core model returns after 6 cycles. Required: req_ready[0] for exactly one cycle, one core_start pulse, core_in=0x00040000 held through WAIT. rsp_id=0, status=00, rsqrt=0x00008000, sqrt=0x00020000, rsp_valid 8 cycles after accept.
- Contention: all four req_valid held high, distinct operands. Required: grant order 0,1,2,3,0; each response id matches its operand; never two req_ready bits set at once.
- Domain: req_in=0x00000000, then 0xFFFF0000 (-1.0). Required: no core_start; status=01, rsqrt=0x7FFFFFFF, sqrt=0; rsp_valid one cycle after accept.
- Timeout: core model never asserts valid, TIMEOUT=64. Required: status=10, results 0, RESP entered 64 cycles after core_start. A late core_valid pulse afterwards is ignored and produces no extra response.
- Backpressure: rsp_ready low for 5 cycles while req_valid[1] is pending. Required: response fields stable the whole time, req_ready stays 0; request 1 is accepted the cycle after the handshake.
- Reset mid-op: resetn low during WAIT, core_valid pulses later. Required: all outputs 0 immediately, no response emitted, next grant goes to requester 0.
